burst_mem_responder: RTL and testbench

- Memory-side responder for the 4-beat x 64-bit burst protocol that the LLC cacheline path drives.
- Accepts one line-aligned read or write request at a time, waits a programmable latency, then performs the 4-beat burst with resp asserted on each beat.
- Backed by an internal line array.
- Serves as the memory endpoint for block-level and cache-subsystem simulation, and as a synthesizable on-chip line memory.

---
 rtl/burst_mem_pkg.sv | 10 +
 rtl/burst_mem_array.sv | 25 ++
 rtl/burst_mem_responder.sv | 119 +++++++++++
 tb/tb_burst_mem_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/burst_mem_pkg.sv
// Shared constants and types for the 4-beat x 64-bit burst memory responder.
package burst_mem_pkg;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = 4;
  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} burst_state_t;
  typedef enum logic {OP_READ, OP_WRITE} burst_op_t;
endpackage

// File: rtl/burst_mem_array.sv
// Line storage: 2**IDX_BITS lines of BEATS x BEAT_W, beat-granular write, combinational beat read.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic [IDX_BITS-1:0] rd_idx,
  input  logic [1:0]          rd_beat,
  output logic [BEAT_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [1:0]          wr_beat,
  input  logic [BEAT_W-1:0]   wr_data
);
  localparam int DEPTH = 1 << IDX_BITS;

  logic [BEATS-1:0][BEAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx][wr_beat] <= wr_data;
  end

  assign rd_data = mem[rd_idx][rd_beat];
endmodule

// File: rtl/burst_mem_responder.sv
// Single-outstanding burst memory responder: accept, wait LATENCY cycles, 4 resp beats, then wait for release.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int LATENCY  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              resp_o,
  output logic              error_o
);
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  burst_state_t        state_q, state_nxt;
  burst_op_t           op_q, op_nxt;
  logic [IDX_BITS-1:0] idx_q, idx_nxt;
  logic [7:0]          lat_q, lat_nxt;
  logic [1:0]          beat_q, beat_nxt;
  logic                drop_q, drop_nxt;
  logic                err_q, err_nxt;
  logic                req_held;
  logic [BEAT_W-1:0]   rd_data;
  logic                wr_en;
  logic                unused_addr;

  // Only the line index bits matter; offset and upper bits alias.
  assign unused_addr = ^{address_i[31:OFFSET_BITS+IDX_BITS], address_i[OFFSET_BITS-1:0]};

  // The request line that must stay high for the latched op.
  assign req_held = (op_q == OP_WRITE) ? write_i : read_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      idx_q   <= '0;
      lat_q   <= '0;
      beat_q  <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      op_q    <= op_nxt;
      idx_q   <= idx_nxt;
      lat_q   <= lat_nxt;
      beat_q  <= beat_nxt;
      drop_q  <= drop_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    op_nxt    = op_q;
    idx_nxt   = idx_q;
    lat_nxt   = lat_q;
    beat_nxt  = beat_q;
    drop_nxt  = drop_q;
    err_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_i && write_i) begin
          err_nxt = 1'b1;
        end else if (read_i || write_i) begin
          state_nxt = WAIT;
          op_nxt    = write_i ? OP_WRITE : OP_READ;
          idx_nxt   = address_i[OFFSET_BITS +: IDX_BITS];
          lat_nxt   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (!req_held) begin
          state_nxt = IDLE;
        end else if (lat_q == 8'd0) begin
          state_nxt = BURST;
          beat_nxt  = 2'd0;
          drop_nxt  = 1'b0;
        end else begin
          lat_nxt = lat_q - 8'd1;
        end
      end
      BURST: begin
        // A mid-burst drop is remembered and reported once after the last beat.
        beat_nxt = beat_q + 2'd1;
        if (!req_held) drop_nxt = 1'b1;
        if (beat_q == 2'd3) begin
          state_nxt = DONE;
          err_nxt   = drop_q | ~req_held;
        end
      end
      DONE: begin
        if (!read_i && !write_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_en   = (state_q == BURST) && (op_q == OP_WRITE);
  assign resp_o  = (state_q == BURST);
  assign burst_o = ((state_q == BURST) && (op_q == OP_READ)) ? rd_data : '0;
  assign error_o = err_q;

  burst_mem_array #(.IDX_BITS(IDX_BITS)) u_array (
    .clk    (clk),
    .rd_idx (idx_q),
    .rd_beat(beat_q),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_idx (idx_q),
    .wr_beat(beat_q),
    .wr_data(burst_i)
  );
endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: LATENCY=3 instance and LATENCY=1 instance.
module tb_burst_mem_responder;
  logic        clk;
  logic        reset_n;
  logic [31:0] addr [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [63:0] bin  [2];
  logic [63:0] bout [2];
  logic        resp [2];
  logic        err  [2];

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q [$];
  logic [63:0] model [2][16][4];
  logic [63:0] wb [4];

  burst_mem_responder #(.IDX_BITS(4), .LATENCY(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .address_i(addr[0]), .read_i(rd[0]), .write_i(wr[0]),
    .burst_i(bin[0]), .burst_o(bout[0]), .resp_o(resp[0]), .error_o(err[0]));

  burst_mem_responder #(.IDX_BITS(4), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address_i(addr[1]), .read_i(rd[1]), .write_i(wr[1]),
    .burst_i(bin[1]), .burst_o(bout[1]), .resp_o(resp[1]), .error_o(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: act=%h exp=%h", tag, act, exp);
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  // Full transaction; returns during the first DONE cycle (+hold) with the request dropped.
  task automatic txn(input int d, input bit is_wr, input logic [31:0] a, input int hold);
    int idx;
    int nb;
    idx = int'(a[8:5]);
    for (int b = 0; b < 4; b++) begin
      if (is_wr) begin
        exp_q.push_back(64'd0);
        model[d][idx][b] = wb[b];
      end else begin
        exp_q.push_back(model[d][idx][b]);
      end
    end
    @(negedge clk);
    addr[d] = a;
    if (is_wr) wr[d] = 1'b1; else rd[d] = 1'b1;
    nb = 0;
    for (int k = 1; k <= lat_of(d) + 8 && nb < 4; k++) begin
      @(negedge clk);
      if (resp[d]) begin
        chk("resp_cycle", 64'(k), 64'(lat_of(d) + 1 + nb));
        chk("q_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("burst_o", bout[d], exp_q.pop_front());
        if (is_wr) bin[d] = wb[nb];
        nb++;
      end
    end
    chk("beat_count", 64'(nb), 64'd4);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("done_resp", 64'(resp[d]), 64'd0);
      chk("done_err", 64'(err[d]), 64'd0);
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  initial begin
    int nb;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0; bin[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_resp", 64'(resp[d]), 64'd0);
      chk("rst_burst", bout[d], 64'd0);
      chk("rst_err", 64'(err[d]), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // write then read, offset-ignore/alias read
    wb[0] = {16{4'h1}}; wb[1] = {16{4'h2}}; wb[2] = {16{4'h3}}; wb[3] = {16{4'h4}};
    txn(0, 1'b1, 32'h0000_0020, 0);
    txn(0, 1'b0, 32'h0000_0020, 0);
    txn(0, 1'b0, 32'h0000_0234, 0);

    // read and write together in IDLE
    @(negedge clk);
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0020;
    @(negedge clk);
    chk("both_err", 64'(err[0]), 64'd1);
    chk("both_resp", 64'(resp[0]), 64'd0);
    rd[0] = 1'b0; wr[0] = 1'b0;
    @(negedge clk);
    chk("both_err_end", 64'(err[0]), 64'd0);
    chk("both_resp2", 64'(resp[0]), 64'd0);
    txn(0, 1'b0, 32'h0000_0020, 0);

    // write dropped in WAIT cycle 2
    @(negedge clk);
    addr[0] = 32'h0000_0020; wr[0] = 1'b1; bin[0] = {16{4'h5}};
    @(negedge clk);
    @(negedge clk);
    wr[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_resp", 64'(resp[0]), 64'd0);
      chk("abort_err", 64'(err[0]), 64'd0);
    end
    txn(0, 1'b0, 32'h0000_0020, 3);

    // async reset after two write beats
    wb[0] = {16{4'hA}}; wb[1] = {16{4'hB}}; wb[2] = {16{4'hC}}; wb[3] = {16{4'hD}};
    @(negedge clk);
    addr[0] = 32'h0000_0020; wr[0] = 1'b1;
    nb = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (resp[0]) begin
        if (nb == 2) break;
        bin[0] = wb[nb];
        nb++;
      end
    end
    chk("pre_rst_beats", 64'(nb), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_resp", 64'(resp[0]), 64'd0);
    chk("rst_mid_burst", bout[0], 64'd0);
    model[0][1][0] = wb[0];
    model[0][1][1] = wb[1];
    wr[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    txn(0, 1'b0, 32'h0000_0020, 0);

    // LATENCY=1: back-to-back, request dropped in the DONE cycle
    wb[0] = 64'h0123_4567_89AB_CDEF; wb[1] = 64'hFEDC_BA98_7654_3210;
    wb[2] = 64'h0F0F_0F0F_F0F0_F0F0; wb[3] = 64'hDEAD_BEEF_CAFE_F00D;
    txn(1, 1'b1, 32'h0000_0040, 0);
    txn(1, 1'b0, 32'h0000_0040, 0);
    wb[0] = 64'h1; wb[1] = 64'h2; wb[2] = 64'h3; wb[3] = 64'h4;
    txn(1, 1'b1, 32'h0000_0040, 0);
    txn(1, 1'b0, 32'h0000_0040, 0);

    chk("q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
